// File: rtl/alu_bitserial.sv
// Bit-serial ALU (AND/OR/ADD/SLT): one 1-bit slice walked LSB-first, one bit per clock.
// Optional build macro ALU_FAST_LOGIC_EN: AND/OR finish without entering the serial loop.
//
// state  | meaning
// -------+----------------------------------------------------------------
// S_IDLE | waiting for start; result/overflow/zero hold the last values
// S_RUN  | one operand bit per edge, carry kept in r_carry
module alu_bitserial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             binvert,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             zero
);

    localparam int              CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST   = CW'(WIDTH - 1);
    localparam logic [1:0]      OP_AND = 2'd0;
    localparam logic [1:0]      OP_OR  = 2'd1;
    localparam logic [1:0]      OP_ADD = 2'd2;
    localparam logic [1:0]      OP_SLT = 2'd3;

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, w_a_nxt;
    logic [WIDTH-1:0] r_b, w_b_nxt;
    logic [1:0]       r_op, w_op_nxt;
    logic             r_binv, w_binv_nxt;
    logic             r_carry, w_carry_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic             r_zero, w_zero_nxt;
    logic             r_done, w_done_nxt;
`ifdef ALU_FAST_LOGIC_EN
    logic             r_fast_pend, w_fast_pend_nxt;
`endif

    logic             w_a_bit, w_b_bit, w_b2, w_sum, w_cout, w_slice, w_set;
    logic [WIDTH-1:0] w_shift, w_final;

    assign w_a_bit = r_a[r_cnt];
    assign w_b_bit = r_b[r_cnt];
    assign w_b2    = w_b_bit ^ r_binv;
    assign w_sum   = w_a_bit ^ w_b2 ^ r_carry;
    assign w_cout  = (w_a_bit & w_b2) | (w_a_bit & r_carry) | (w_b2 & r_carry);
    // True sign of a-b: only trust the sum bit when the operand signs differ.
    assign w_set   = (w_a_bit != w_b2) ? w_sum : w_a_bit;

    always_comb begin
        w_slice = 1'b0;
        case (r_op)
            OP_AND:  w_slice = w_a_bit & w_b_bit;
            OP_OR:   w_slice = w_a_bit | w_b_bit;
            OP_ADD:  w_slice = w_sum;
            default: w_slice = 1'b0;
        endcase
    end

    assign w_shift = {w_slice, r_result[WIDTH-1:1]};
    assign w_final = (r_op == OP_SLT) ? {{(WIDTH-1){1'b0}}, w_set} : w_shift;

    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_op_nxt     = r_op;
        w_binv_nxt   = r_binv;
        w_carry_nxt  = r_carry;
        w_cnt_nxt    = r_cnt;
        w_result_nxt = r_result;
        w_ovf_nxt    = r_ovf;
        w_zero_nxt   = r_zero;
        w_done_nxt   = 1'b0;
`ifdef ALU_FAST_LOGIC_EN
        w_fast_pend_nxt = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
`ifdef ALU_FAST_LOGIC_EN
                if (r_fast_pend) begin
                    // result already written; hold off new work until done pulses
                    w_done_nxt = 1'b1;
                end else if (start && (op == OP_AND || op == OP_OR)) begin
                    w_result_nxt    = (op == OP_AND) ? (a & b) : (a | b);
                    w_zero_nxt      = (w_result_nxt == '0);
                    w_ovf_nxt       = 1'b0;
                    w_fast_pend_nxt = 1'b1;
                end else
`endif
                if (start) begin
                    w_a_nxt     = a;
                    w_b_nxt     = b;
                    w_op_nxt    = op;
                    w_binv_nxt  = binvert;
                    w_carry_nxt = binvert;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_carry_nxt  = w_cout;
                w_cnt_nxt    = r_cnt + 1'b1;
                w_result_nxt = w_shift;
                if (r_cnt == LAST) begin
                    w_result_nxt = w_final;
                    w_ovf_nxt    = (r_op == OP_ADD) && (w_a_bit == w_b2) && (w_sum != w_a_bit);
                    w_zero_nxt   = (w_final == '0);
                    w_done_nxt   = 1'b1;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_binv   <= 1'b0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_op     <= w_op_nxt;
            r_binv   <= w_binv_nxt;
            r_carry  <= w_carry_nxt;
            r_cnt    <= w_cnt_nxt;
            r_result <= w_result_nxt;
            r_ovf    <= w_ovf_nxt;
            r_zero   <= w_zero_nxt;
            r_done   <= w_done_nxt;
        end
    end

`ifdef ALU_FAST_LOGIC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fast_pend <= 1'b0;
        else        r_fast_pend <= w_fast_pend_nxt;
    end
`endif

    assign busy     = (r_state == S_RUN);
    assign done     = r_done;
    assign result   = r_result;
    assign overflow = r_ovf;
    assign zero     = r_zero;

endmodule

// File: doc/alu_bitserial.md
Name: alu_bitserial

Overview:
Multi-cycle, bit-serial counterpart to the combinational sliced ALU. It drives one 1-bit slice datapath across all operand bits, LSB first, one bit per clock. It keeps carry state between cycles and routes the MSB "set" result back into bit 0 for SLT. It sits beside the sliced ALU as an area-reduced execution unit with a start/done handshake.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when idle
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
op  input  2  0=AND, 1=OR, 2=ADD, 3=SLT; captured on accepted start
binvert  input  1  invert B and set carry-in=1 (subtract); captured on accepted start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when result/overflow/zero are valid
result  output  WIDTH  operation result, held until the next accepted start
overflow  output  1  signed overflow, ADD op only
zero  output  1  result == 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: busy=0, done=0, result=0, overflow=0, zero=0, internal carry=0, bit counter=0, state=IDLE.
- State machine:
  - States are IDLE and RUN.
  - IDLE: start=1 at a clock edge captures a, b, op and binvert. It also sets carry=binvert, counter=0, busy=1, and moves to RUN.
  - RUN: each edge processes bit i = counter.
    - b2_i = binvert ? ~b_i : b_i.
    - sum_i = a_i ^ b2_i ^ carry.
    - carry <= majority(a_i, b2_i, carry).
    - The slice bit is a_i&b_i (AND), a_i|b_i (OR), sum_i (ADD), or 0 (SLT). It shifts into result from the MSB side (right shift).
    - counter increments.
  - Final RUN edge (counter == WIDTH-1):
    - Overflow is computed from the MSB: a_msb == b2_msb and sum_msb != a_msb; it is forced to 0 unless op == ADD.
    - set = (a_msb != b2_msb) ? sum_msb : a_msb, i.e. the true sign of a - b independent of overflow.
    - For SLT, result is written as {WIDTH-1 zeros, set}.
    - zero is registered from the final result value.
    - done=1 for exactly one cycle, busy=0, state goes to IDLE.
- Latency: done is high in the cycle following the WIDTH-th edge after the start-accept edge, i.e. WIDTH+1 edges from start sampling.
- start while busy=1 is ignored; captured operands never change mid-operation.
- start high during the done cycle is accepted (state is already IDLE); done still deasserts on the next edge.
- Input changes on a, b, op and binvert after capture have no effect.
- SLT is specified only with binvert=1. With binvert=0 the result is {0..., set-of-(a+b)} and the bench does not check it.
- Reset asserted mid-operation clears all state immediately. No done pulse is produced for the aborted operation.
- result, overflow and zero hold their last values while idle. During RUN, result holds partially shifted bits and is undefined to the consumer until done.

Optional Feature:
ALU_FAST_LOGIC_EN
- Defined: AND and OR complete in one edge. The start-accept edge writes result = a&b or a|b and zero, and pulses done on the next cycle; busy never rises.
- Not defined: all ops take the full WIDTH-cycle serial path described above.
- ADD and SLT timing is identical in both builds.

Test Plan:
- WIDTH=8, op=ADD, binvert=0, a=0x7F, b=0x01, start -> after 9 edges done=1, result=0x80, overflow=1, zero=0.
- op=ADD, binvert=1, a=0x05, b=0x05 -> result=0x00, zero=1, overflow=0.
- op=SLT, binvert=1, a=0xFE, b=0x01 -> result=0x01. Then a=0x7F, b=0x80 -> result=0x00, overflow=0 (set is correct despite sub overflow).
- op=AND, a=0xF0, b=0x3C -> result=0x30; done at edge 9 without the macro, edge 2 with ALU_FAST_LOGIC_EN.
- start re-pulsed at edge 3 of an ADD with different operands -> ignored; first result is returned, and a new start in the done cycle is accepted.
- rst_n pulled low at edge 4 of an ADD -> busy, done, result and overflow go to 0 immediately; no done pulse follows the release.
